adc_sar_sequencer: RTL and testbench



---
 rtl/adc_sar_sequencer.sv | 158 +++++++++++++++
 tb/tb_adc_sar_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sar_sequencer.sv
// adc_sar_sequencer: sample/convert sequencer for the 10-bit SAR ADC logic.
// Drives the registered sample strobe for max(samp_len,1) cycles, waits for
// the SAR end-of-conversion pulse, captures the code and offers it over a
// valid/ready handshake. Single-shot and continuous modes.
// Optional feature macro: ADC_SEQ_TIMEOUT_EN (conversion timeout watchdog).
module adc_sar_sequencer #(
    parameter int unsigned DATA_W         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic [3:0]        samp_len,
    input  logic              ovr_clr,
    output logic              busy,
    output logic              adc_samp,
    input  logic              adc_eoc,
    input  logic [DATA_W-1:0] adc_b,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overrun,
    output logic              timeout
);

    // The watchdog must not fire before a normal conversion can complete.
    if (TIMEOUT_CYCLES < 12) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 12");
    end

    typedef enum logic [1:0] {StIdle, StSample, StConvert} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              samp_q, samp_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic [3:0]        samp_len_eff;
    logic              eoc_take;
    logic              tmo_hit;

    assign samp_len_eff = (samp_len == 4'd0) ? 4'd1 : samp_len;
    // eoc is only meaningful while a conversion is in flight.
    assign eoc_take     = (state_q == StConvert) && adc_eoc;

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q;

    assign tmo_hit   = (state_q == StConvert) && !adc_eoc &&
                       (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
    assign tmo_cnt_d = (state_q == StConvert) ? tmo_cnt_q + 1'b1 : '0;
    assign timeout   = timeout_q;

    // Watchdog counter and one-cycle timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    // Next-state and sample-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start || continuous) begin
                    state_d = StSample;
                    cnt_d   = samp_len_eff;
                end
            end
            StSample: begin
                if (cnt_q == 4'd1) begin
                    state_d = StConvert;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StConvert: begin
                if (adc_eoc) begin
                    if (continuous) begin
                        state_d = StSample;
                        cnt_d   = samp_len_eff;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (tmo_hit) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Capture, handshake and sticky overrun; a new overrun beats ovr_clr.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        samp_d  = (state_d == StSample);
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (eoc_take) begin
            if (!valid_q || data_ready) begin
                data_d  = adc_b;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            samp_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            samp_q  <= samp_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign adc_samp   = samp_q;
    assign data       = data_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Testbench for adc_sar_sequencer: timeline-based reference model checked on
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_adc_sar_sequencer;

    localparam int unsigned DW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic [3:0]    samp_len = 4'd0;
    logic          ovr_clr = 1'b0;
    logic          busy, adc_samp, data_valid, overrun, timeout;
    logic          adc_eoc;
    logic [DW-1:0] adc_b = '0;
    logic [DW-1:0] data;
    logic          data_ready = 1'b0;

    logic sar_eoc = 1'b0;
    logic spur_eoc = 1'b0;
    logic sar_en = 1'b0;
    assign adc_eoc = sar_eoc | spur_eoc;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] codes [0:15];
    int            code_idx = 0;

    adc_sar_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .samp_len   (samp_len),
        .ovr_clr    (ovr_clr),
        .busy       (busy),
        .adc_samp   (adc_samp),
        .adc_eoc    (adc_eoc),
        .adc_b      (adc_b),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a conversion is a timeline anchored at its start edge t0.
    // Sampling covers edges t0..t0+L-1, eoc counts from edge t0+L+1 onward.
    int            pc = 0;
    int            m_t0 = 0;
    int            m_len = 1;
    logic          m_busy = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic          m_valid = 1'b0;
    logic          m_ovr = 1'b0;
    logic          m_tmo = 1'b0;

    initial begin
        int  el;
        bit  cap, tmo;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy  = 1'b0;
                m_data  = '0;
                m_valid = 1'b0;
                m_ovr   = 1'b0;
                m_tmo   = 1'b0;
                m_t0    = pc;
                m_len   = 1;
            end else begin
                pc++;
                el  = pc - m_t0;
                cap = m_busy && (el > m_len) && adc_eoc;
                tmo = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
                tmo = m_busy && !cap && (el == m_len + 15);
`endif
                if (cap && m_valid && !data_ready) begin
                    m_ovr = 1'b1;
                end else begin
                    if (ovr_clr) m_ovr = 1'b0;
                    if (cap) begin
                        m_data  = adc_b;
                        m_valid = 1'b1;
                    end else if (m_valid && data_ready) begin
                        m_valid = 1'b0;
                    end
                end
                m_tmo = tmo;
                if (m_busy) begin
                    if (cap) begin
                        if (continuous) begin
                            m_t0  = pc;
                            m_len = (samp_len == 0) ? 1 : int'(samp_len);
                        end else begin
                            m_busy = 1'b0;
                        end
                    end else if (tmo) begin
                        m_busy = 1'b0;
                    end
                end else if (start || continuous) begin
                    m_busy = 1'b1;
                    m_t0   = pc;
                    m_len  = (samp_len == 0) ? 1 : int'(samp_len);
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("busy", 32'(busy), 32'(m_busy));
            check("adc_samp", 32'(adc_samp), 32'(m_busy && ((pc - m_t0) < m_len)));
            check("data", 32'(data), 32'(m_data));
            check("data_valid", 32'(data_valid), 32'(m_valid));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("timeout", 32'(timeout), 32'(m_tmo));
        end
    end

    // SAR responder: eoc on the 11th edge after the adc_samp fall.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (sar_en && prev && !adc_samp) begin
                repeat (10) @(negedge clk);
                adc_b    = codes[code_idx];
                code_idx = code_idx + 1;
                sar_eoc  = 1'b1;
                @(negedge clk);
                sar_eoc = 1'b0;
            end
            prev = adc_samp;
        end
    end

    initial begin
        int n_samp, n_valid, first_valid, first_tmo, n_tmo, i1;
        logic [DW-1:0] first_data;
        logic          busy_at_tmo;

        codes[0] = 10'h2A5; codes[1] = 10'h155; codes[2] = 10'h001; codes[3] = 10'h002;
        codes[4] = 10'h003; codes[5] = 10'h0AA; codes[6] = 10'h0BB; codes[7] = 10'h0CC;
        for (int k = 8; k < 16; k++) codes[k] = 10'h0DD;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_samp", 32'(adc_samp), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);

        // Single-shot, samp_len=3, code 2A5.
        sar_en = 1'b1; samp_len = 4'd3; data_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        n_samp = 0; n_valid = 0; first_valid = 0; first_data = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (adc_samp) n_samp++;
            if (data_valid) begin
                n_valid++;
                if (first_valid == 0) begin
                    first_valid = i;
                    first_data  = data;
                end
            end
        end
        check("t1_samp_cycles", 32'(n_samp), 32'd3);
        check("t1_valid_cycles", 32'(n_valid), 32'd1);
        check("t1_valid_at", 32'(first_valid), 32'd15);
        check("t1_data", 32'(first_data), 32'h2A5);
        check("t1_busy_end", 32'(busy), 32'd0);

        // Single-shot, samp_len=0 behaves as 1.
        samp_len = 4'd0;
        start = 1'b1;
        n_samp = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (adc_samp) n_samp++;
        end
        check("t2_samp_cycles", 32'(n_samp), 32'd1);
        check("t2_data", 32'(data), 32'h155);

        // Continuous with no consumer: codes dropped, overrun sticky.
        samp_len = 4'd2; data_ready = 1'b0; continuous = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 20) begin
                check("t3_first_data", 32'(data), 32'h001);
                check("t3_first_ovr", 32'(overrun), 32'd0);
            end
            if (i == 30) continuous = 1'b0;
        end
        check("t3_data_kept", 32'(data), 32'h001);
        check("t3_valid", 32'(data_valid), 32'd1);
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_idle", 32'(busy), 32'd0);
        ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        check("t3_ovr_clr", 32'(overrun), 32'd0);
        data_ready = 1'b1;
        @(negedge clk); data_ready = 1'b0;
        check("t3_drained", 32'(data_valid), 32'd0);

        // Continuous, ready coincident with the second capture.
        continuous = 1'b1; i1 = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i1 == 0 && data_valid) i1 = i;
            if (i1 != 0 && i == i1 + 12) data_ready = 1'b1;
            if (i1 != 0 && i == i1 + 13) begin
                check("t4_data", 32'(data), 32'h0BB);
                check("t4_valid", 32'(data_valid), 32'd1);
                check("t4_overrun", 32'(overrun), 32'd0);
                continuous = 1'b0;
            end
        end
        check("t4_first_at", 32'(i1), 32'd14);
        check("t4_last_data", 32'(data), 32'h0CC);

        // Async reset during CONVERT, then eoc while idle is ignored.
        samp_len = 4'd1; data_ready = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_samp", 32'(adc_samp), 32'd0);
        check("t5_data", 32'(data), 32'd0);
        check("t5_valid", 32'(data_valid), 32'd0);
        check("t5_overrun", 32'(overrun), 32'd0);
        check("t5_timeout", 32'(timeout), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        n_valid = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            spur_eoc = (i == 15);
            if (data_valid || busy) n_valid++;
        end
        spur_eoc = 1'b0;
        check("t5_spurious_eoc", 32'(n_valid), 32'd0);

        // No eoc at all.
        sar_en = 1'b0; samp_len = 4'd2;
        start = 1'b1;
        first_tmo = 0; n_tmo = 0; n_valid = 0; busy_at_tmo = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (timeout) begin
                n_tmo++;
                if (first_tmo == 0) begin
                    first_tmo   = i;
                    busy_at_tmo = busy;
                end
            end
            if (data_valid) n_valid++;
        end
        check("t6_no_valid", 32'(n_valid), 32'd0);
`ifdef ADC_SEQ_TIMEOUT_EN
        check("t6_timeout_at", 32'(first_tmo), 32'd18);
        check("t6_timeout_cycles", 32'(n_tmo), 32'd1);
        check("t6_busy_at_timeout", 32'(busy_at_tmo), 32'd0);
        check("t6_idle_end", 32'(busy), 32'd0);
`else
        check("t6_no_timeout", 32'(n_tmo), 32'd0);
        check("t6_still_waiting", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
`endif
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
